// File: rtl/wb_spi_arbiter.sv
// Two-master Wishbone arbiter in front of a single SPI core slave.
// Round-robin on ties, grant held while cyc is high, strobe timeout forces an error.
module wb_spi_arbiter #(
   parameter int AW      = 5,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   // master 0
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [AW-1:0]     m0_adr_i,
   input  logic [DW-1:0]     m0_dat_i,
   input  logic [DW/8-1:0]   m0_sel_i,
   output logic [DW-1:0]     m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   // master 1
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [AW-1:0]     m1_adr_i,
   input  logic [DW-1:0]     m1_dat_i,
   input  logic [DW/8-1:0]   m1_sel_i,
   output logic [DW-1:0]     m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   // slave (SPI core)
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [AW-1:0]     s_adr_o,
   output logic [DW-1:0]     s_dat_o,
   output logic [DW/8-1:0]   s_sel_o,
   input  logic [DW-1:0]     s_dat_i,
   input  logic              s_ack_i,
   input  logic              s_err_i,
   // status
   output logic [1:0]        gnt_o,
   output logic              timeout_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            last_gnt_q, last_gnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            req0, req1;
   logic            busy, owner;
   logic            own_cyc, own_stb, own_we;
   logic [AW-1:0]   own_adr;
   logic [DW-1:0]   own_dat;
   logic [DW/8-1:0] own_sel;
   logic            stb_req, timeout_hit, ack_fwd, err_fwd;

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

   // Read data is broadcast; each master qualifies it with its own ack.
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      cnt_d       = '0;
      busy        = (state_q == BUSY0) || (state_q == BUSY1);
      owner       = (state_q == BUSY1);
      own_cyc     = owner ? m1_cyc_i : m0_cyc_i;
      own_stb     = owner ? m1_stb_i : m0_stb_i;
      own_we      = owner ? m1_we_i  : m0_we_i;
      own_adr     = owner ? m1_adr_i : m0_adr_i;
      own_dat     = owner ? m1_dat_i : m0_dat_i;
      own_sel     = owner ? m1_sel_i : m0_sel_i;
      stb_req     = 1'b0;
      timeout_hit = 1'b0;
      ack_fwd     = 1'b0;
      err_fwd     = 1'b0;
      s_cyc_o     = 1'b0;
      s_stb_o     = 1'b0;
      s_we_o      = 1'b0;
      s_adr_o     = '0;
      s_dat_o     = '0;
      s_sel_o     = '0;
      m0_ack_o    = 1'b0;
      m0_err_o    = 1'b0;
      m1_ack_o    = 1'b0;
      m1_err_o    = 1'b0;
      gnt_o       = 2'b00;
      timeout_o   = 1'b0;

      if (state_q == IDLE) begin
         // last_gnt_q = 1 means master 1 went last, so master 0 wins a tie.
         if (req0 && req1)  state_d = last_gnt_q ? BUSY0 : BUSY1;
         else if (req0)     state_d = BUSY0;
         else if (req1)     state_d = BUSY1;
      end else if (busy) begin
         stb_req     = own_cyc & own_stb;
         timeout_hit = stb_req & ~s_ack_i & ~s_err_i & (cnt_q == TO_LAST);
         s_cyc_o     = own_cyc;
         s_stb_o     = stb_req & ~timeout_hit;
         s_we_o      = own_we;
         s_adr_o     = own_adr;
         s_dat_o     = own_dat;
         s_sel_o     = own_sel;
         // An error response wins over a simultaneous ack.
         ack_fwd     = s_ack_i & ~s_err_i;
         err_fwd     = s_err_i | timeout_hit;
         timeout_o   = timeout_hit;
         m0_ack_o    = ack_fwd & ~owner;
         m0_err_o    = err_fwd & ~owner;
         m1_ack_o    = ack_fwd &  owner;
         m1_err_o    = err_fwd &  owner;
         gnt_o       = owner ? 2'b10 : 2'b01;
         if (s_stb_o && !s_ack_i && !s_err_i)
            cnt_d = cnt_q + 1'b1;
         if (!own_cyc) begin
            state_d    = IDLE;
            last_gnt_d = owner;
         end
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
      if (wb_rst_i) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Directed bench for wb_spi_arbiter: grant order, routing, timeout and reset behaviour.
module tb_wb_spi_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [AW-1:0]   m0_adr, m1_adr;
   logic [DW-1:0]   m0_dat, m1_dat;
   logic [DW/8-1:0] m0_sel, m1_sel;
   logic [DW-1:0]   m0_dat_o, m1_dat_o;
   logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic            s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o;
   logic [DW/8-1:0] s_sel_o;
   logic [DW-1:0]   s_dat;
   logic            s_ack, s_err;
   logic [1:0]      gnt_o;
   logic            timeout_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wb_spi_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
      .wb_clk_i (clk),      .wb_rst_i (rst),
      .m0_cyc_i (m0_cyc),   .m0_stb_i (m0_stb),   .m0_we_i  (m0_we),
      .m0_adr_i (m0_adr),   .m0_dat_i (m0_dat),   .m0_sel_i (m0_sel),
      .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
      .m1_cyc_i (m1_cyc),   .m1_stb_i (m1_stb),   .m1_we_i  (m1_we),
      .m1_adr_i (m1_adr),   .m1_dat_i (m1_dat),   .m1_sel_i (m1_sel),
      .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
      .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
      .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o  (s_sel_o),
      .s_dat_i  (s_dat),    .s_ack_i  (s_ack),    .s_err_i  (s_err),
      .gnt_o    (gnt_o),    .timeout_o(timeout_o)
   );

   task automatic idle_inputs();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
      s_dat = '0; s_ack = 0; s_err = 0;
   endtask

   // Leaves the bench 1 time unit after the edge that sampled reset.
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1;
      idle_inputs();
      @(posedge clk);
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_cmp++;
      if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
      n_cmp++;
      if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin
         n_bad++; $display("FAIL reset_s_ctrl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o});
      end
      n_cmp++;
      if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o} !== 5'b00000) begin
         n_bad++; $display("FAIL reset_resp: got %b want 00000",
                           {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o});
      end
   endtask

   task automatic test_single();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 5'h04; m0_dat = 32'hA5; m0_sel = 4'hF;
      #1;
      n_cmp++;
      if (s_stb_o !== 1'b0) begin n_bad++; $display("FAIL single_stb_early: got %b want 0", s_stb_o); end
      @(posedge clk); #1;
      n_cmp++;
      if ({gnt_o, s_cyc_o, s_stb_o, s_we_o} !== 5'b01111) begin
         n_bad++; $display("FAIL single_grant: got %b want 01111", {gnt_o, s_cyc_o, s_stb_o, s_we_o});
      end
      n_cmp++;
      if ({s_adr_o, s_dat_o, s_sel_o} !== {5'h04, 32'hA5, 4'hF}) begin
         n_bad++; $display("FAIL single_fwd: got %h/%h/%h want 04/a5/f", s_adr_o, s_dat_o, s_sel_o);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (m0_ack_o !== 1'b0) begin n_bad++; $display("FAIL single_ack_early: got %b want 0", m0_ack_o); end
      @(posedge clk); #1;
      s_ack = 1; s_dat = 32'h1234_5678;
      #1;
      n_cmp++;
      if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
         n_bad++; $display("FAIL single_ack: got %b want 10", {m0_ack_o, m1_ack_o});
      end
      n_cmp++;
      if (m0_dat_o !== 32'h1234_5678) begin
         n_bad++; $display("FAIL single_rdata: got %h want 12345678", m0_dat_o);
      end
      @(posedge clk); #1;
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      #1;
      n_cmp++;
      if ({m0_ack_o, s_cyc_o, gnt_o} !== 4'b0001) begin
         n_bad++; $display("FAIL single_release: got %b want 0001", {m0_ack_o, s_cyc_o, gnt_o});
      end
      @(posedge clk); #1;
      s_ack = 1;
      #1;
      n_cmp++;
      if ({gnt_o, m0_ack_o, m1_ack_o} !== 4'b0000) begin
         n_bad++; $display("FAIL single_late_ack: got %b want 0000", {gnt_o, m0_ack_o, m1_ack_o});
      end
      s_ack = 0;
   endtask

   task automatic test_tie();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_adr = 5'h01;
      m1_cyc = 1; m1_stb = 1; m1_adr = 5'h02;
      @(posedge clk); #1;
      s_ack = 1;
      #1;
      n_cmp++;
      if ({gnt_o, s_adr_o} !== {2'b01, 5'h01}) begin
         n_bad++; $display("FAIL tie_first: got %b/%h want 01/01", gnt_o, s_adr_o);
      end
      n_cmp++;
      if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
         n_bad++; $display("FAIL tie_ack_route: got %b want 10", {m0_ack_o, m1_ack_o});
      end
      @(posedge clk); #1;
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      @(posedge clk); #2;
      n_cmp++;
      if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL tie_idle_gap: got %b want 00", gnt_o); end
      @(posedge clk); #2;
      n_cmp++;
      if ({gnt_o, s_adr_o} !== {2'b10, 5'h02}) begin
         n_bad++; $display("FAIL tie_second: got %b/%h want 10/02", gnt_o, s_adr_o);
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_gnt;
      do_reset();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      for (int i = 0; i < 6; i++) begin
         exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
         @(posedge clk); #1;
         s_ack = 1;
         #1;
         n_cmp++;
         if (gnt_o !== exp_gnt) begin
            n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, gnt_o, exp_gnt);
         end
         @(posedge clk); #1;
         s_ack = 0;
         if (i % 2 == 0) begin m0_cyc = 0; m0_stb = 0; end
         else            begin m1_cyc = 0; m1_stb = 0; end
         @(posedge clk); #1;
         n_cmp++;
         if (gnt_o !== 2'b00) begin n_bad++; $display("FAIL rr_idle[%0d]: got %b want 00", i, gnt_o); end
         m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      end
      idle_inputs();
   endtask

   task automatic test_timeout();
      int bad_cycles;
      bad_cycles = 0;
      do_reset();
      m0_cyc = 1; m0_stb = 1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #2;
         if (s_stb_o !== 1'b1 || m0_err_o !== 1'b0 || timeout_o !== 1'b0) bad_cycles++;
      end
      n_cmp++;
      if (bad_cycles !== 0) begin
         n_bad++; $display("FAIL to_wait: got %0d bad strobe cycles want 0", bad_cycles);
      end
      @(posedge clk); #2;
      n_cmp++;
      if ({m0_err_o, timeout_o, s_stb_o, m1_err_o} !== 4'b1100) begin
         n_bad++; $display("FAIL to_fire: got %b want 1100", {m0_err_o, timeout_o, s_stb_o, m1_err_o});
      end
      n_cmp++;
      if ({gnt_o, s_cyc_o} !== 3'b011) begin
         n_bad++; $display("FAIL to_hold_grant: got %b want 011", {gnt_o, s_cyc_o});
      end
      @(posedge clk); #2;
      n_cmp++;
      if ({m0_err_o, timeout_o, s_stb_o, gnt_o} !== 5'b00101) begin
         n_bad++; $display("FAIL to_after: got %b want 00101", {m0_err_o, timeout_o, s_stb_o, gnt_o});
      end
      idle_inputs();
   endtask

   task automatic test_ack_err();
      do_reset();
      m1_cyc = 1; m1_stb = 1;
      @(posedge clk); #1;
      s_ack = 1; s_err = 1;
      #1;
      n_cmp++;
      if ({m1_err_o, m1_ack_o, m0_err_o, m0_ack_o} !== 4'b1000) begin
         n_bad++; $display("FAIL ack_err: got %b want 1000", {m1_err_o, m1_ack_o, m0_err_o, m0_ack_o});
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      m1_cyc = 1; m1_stb = 1;
      @(posedge clk); #2;
      n_cmp++;
      if (gnt_o !== 2'b10) begin n_bad++; $display("FAIL rstmid_busy1: got %b want 10", gnt_o); end
      rst = 1;
      @(posedge clk); #1;
      rst = 0; s_ack = 1;
      m0_cyc = 1; m0_stb = 1;
      #1;
      n_cmp++;
      if ({gnt_o, s_cyc_o, m0_ack_o, m1_ack_o} !== 5'b00000) begin
         n_bad++; $display("FAIL rstmid_abandon: got %b want 00000", {gnt_o, s_cyc_o, m0_ack_o, m1_ack_o});
      end
      s_ack = 0;
      @(posedge clk); #2;
      n_cmp++;
      if (gnt_o !== 2'b01) begin n_bad++; $display("FAIL rstmid_tie: got %b want 01", gnt_o); end
      idle_inputs();
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_single();
      test_tie();
      test_back_to_back();
      test_timeout();
      test_ack_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/wb_spi_arbiter.md
WB_SPI_ARBITER -- requirements
Module: wb_spi_arbiter

Interface
REQ-001 SHALL have parameter AW, default 5: Wishbone address width for the SPI core register space.
REQ-002 SHALL have parameter DW, default 32: Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT, default 16: number of unacknowledged strobe cycles before the block forces an error (minimum 2).
REQ-004 SHALL use one clock and a synchronous, active-high reset: wb_clk_i  input  1  Wishbone clock, all logic on the rising edge.
REQ-005 SHALL have wb_rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  master-0 Wishbone cycle, strobe and write enable.
REQ-007 SHALL have m0_adr_i  input  AW, m0_dat_i  input  DW, m0_sel_i  input  DW/8  master-0 address, write data and byte select.
REQ-008 SHALL have m0_dat_o  output  DW, m0_ack_o  output  1, m0_err_o  output  1  master-0 read data, acknowledge and error.
REQ-009 SHALL have an identical port set for master 1, with the prefix m1_.
REQ-010 SHALL have s_cyc_o, s_stb_o, s_we_o  output  1 each, s_adr_o  output  AW, s_dat_o  output  DW, s_sel_o  output  DW/8  as the slave-side (SPI core) request.
REQ-011 SHALL have s_dat_i  input  DW, s_ack_i  input  1, s_err_i  input  1  as the slave-side response.
REQ-012 SHALL have gnt_o  output  2  one-hot current grant, bit n set for master n, and timeout_o  output  1  one-cycle pulse on a forced error.

Function
REQ-013 SHALL implement three states: IDLE, BUSY0 and BUSY1.
REQ-014 SHALL define the request of master n as mN_cyc_i & mN_stb_i.
REQ-015 SHALL, in IDLE, move to BUSYn on the next edge when only master n requests.
REQ-016 SHALL, in IDLE with both masters requesting, grant the master other than last_gnt (round robin).
REQ-017 SHALL register the grant, so that s_cyc_o and s_stb_o rise no earlier than one cycle after the request is first seen in IDLE.
REQ-018 SHALL, in BUSYn, drive s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o combinationally from master n's inputs.
REQ-019 SHALL, in IDLE, hold s_cyc_o, s_stb_o and s_we_o at 0, and s_adr_o, s_dat_o and s_sel_o at 0.
REQ-020 SHALL route s_ack_i and s_err_i only to the granted master; the non-granted master's ack_o and err_o SHALL be 0.
REQ-021 SHALL drive both m0_dat_o and m1_dat_o with s_dat_i; the data is valid only with the corresponding ack.
REQ-022 SHALL, when s_ack_i and s_err_i are both high, pass err only and suppress ack.
REQ-023 SHALL hold the grant for as long as mN_cyc_i stays high, so that block and back-to-back strobes stay with one master.
REQ-024 SHALL, when mN_cyc_i falls in BUSYn, drop s_cyc_o in the same cycle, move to IDLE on the next edge and set last_gnt to n.
REQ-025 SHALL therefore have at least one IDLE cycle between consecutive grants.
REQ-026 SHALL treat master n dropping cyc before ack (abort) like a normal release; a late s_ack_i in IDLE SHALL be ignored.
REQ-027 SHALL keep a timeout counter of width clog2(TIMEOUT+1) that increments each cycle with s_stb_o=1 and s_ack_i=s_err_i=0.
REQ-028 SHALL clear the timeout counter on ack, on err, on s_stb_o=0 and in IDLE.
REQ-029 SHALL, when the counter equals TIMEOUT-1 and no response arrives, in that same cycle force s_stb_o=0, assert mN_err_o=1 and pulse timeout_o=1, then clear the counter.
REQ-030 SHALL NOT release the grant on a timeout; the master decides by dropping cyc.
REQ-031 SHALL make gnt_o = 2'b01 in BUSY0, 2'b10 in BUSY1 and 2'b00 in IDLE.

Reset
REQ-032 SHALL, on wb_rst_i=1 at a clock edge, set the state to IDLE, last_gnt to 1 (master 0 wins the first tie), the counter to 0, gnt_o to 0 and timeout_o to 0.
REQ-033 SHALL hold all slave control outputs and all master ack/err outputs at 0 from the cycle after reset is sampled.
REQ-034 SHALL, when reset is asserted mid-transfer, abandon the transfer without an ack to either master.

Verification
REQ-035 SHALL cover single request: m0 write, adr=0x04, dat=0xA5, with the slave acking 2 cycles after strobe -> s_stb_o rises 1 cycle after the request, m0_ack_o is a 1-cycle pulse, m1_ack_o stays 0.
REQ-036 SHALL cover a tie after reset: m0 and m1 request in the same cycle -> gnt_o=01 first; after m0 drops cyc, one IDLE cycle, then gnt_o=10.
REQ-037 SHALL cover a sustained tie: both masters request continuously for 6 single transfers -> grants alternate 0,1,0,1,0,1.
REQ-038 SHALL cover timeout: TIMEOUT=16, the slave never responds -> after 15 strobe cycles, m0_err_o=1, timeout_o=1 and s_stb_o=0 for 1 cycle; the grant is retained.
REQ-039 SHALL cover simultaneous s_ack_i=s_err_i=1 -> err_o=1 and ack_o=0 for the granted master.
REQ-040 SHALL cover reset mid-transfer in BUSY1 -> the next cycle shows gnt_o=00 and s_cyc_o=0, and a subsequent tie is granted to m0.
